// File: rtl/trigger_out_shaper.sv
// trigger_out_shaper: turns rising edges of the merged trigger level into a
// delayed, programmable-width strobe followed by a holdoff window. Edges that
// arrive while a strobe sequence is in flight are rejected and counted.
module trigger_out_shaper #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_out_en,
  input  logic [CNT_W-1:0] reg_out_delay,
  input  logic [CNT_W-1:0] reg_out_width,
  input  logic [CNT_W-1:0] reg_out_holdoff,
  input  logic             reg_cnt_clr,
  input  logic             trigger_in,
  output logic             trig_out,
  output logic             busy,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             trig_d;
  logic             rise;
  logic             accept_now;
  logic             accept_p0;
  logic             drop_p0;
  logic [CNT_W-1:0] sh_delay;
  logic [CNT_W-1:0] sh_width_m1;
  logic [CNT_W-1:0] sh_holdoff;
  logic [CNT_W-1:0] cnt;

  // The accept/drop decision is taken against the state seen at the sampling
  // edge; a pending accept still counts as occupied so it cannot be doubled.
  assign rise       = trigger_in & ~trig_d;
  assign accept_now = rise & reg_out_en & (state == IDLE) & ~accept_p0;

  // Edge detect and accept/drop decision, one clock ahead of the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_d    <= 1'b0;
      accept_p0 <= 1'b0;
      drop_p0   <= 1'b0;
    end else begin
      trig_d    <= trigger_in;
      accept_p0 <= accept_now;
      drop_p0   <= rise & reg_out_en & ((state != IDLE) | accept_p0);
    end
  end

  // Shadow copies of D, W-1 (W=0 treated as 1) and H taken on acceptance
  always_ff @(posedge clk) begin
    if (accept_now) begin
      sh_delay    <= reg_out_delay;
      sh_width_m1 <= (reg_out_width == '0) ? '0 : reg_out_width - ONE;
      sh_holdoff  <= reg_out_holdoff;
    end
  end

  // Strobe sequencer: each phase loads its length minus one and counts to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      trig_out <= 1'b0;
      busy     <= 1'b0;
    end else if (!reg_out_en) begin
      state    <= IDLE;
      trig_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_p0) begin
            busy <= 1'b1;
            if (sh_delay != '0) begin
              state <= DELAY;
              cnt   <= sh_delay - ONE;
            end else begin
              state    <= PULSE;
              cnt      <= sh_width_m1;
              trig_out <= 1'b1;
            end
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            state    <= PULSE;
            cnt      <= sh_width_m1;
            trig_out <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            trig_out <= 1'b0;
            if (sh_holdoff != '0) begin
              state <= HOLDOFF;
              cnt   <= sh_holdoff - ONE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        HOLDOFF: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state    <= IDLE;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else if (reg_cnt_clr) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (accept_p0 && (accept_cnt != CNT_MAX)) accept_cnt <= accept_cnt + ONE;
      if (drop_p0 && (drop_cnt != CNT_MAX))     drop_cnt   <= drop_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_trigger_out_shaper.sv
// Bench for trigger_out_shaper: a 32-bit instance for timing/behaviour and a
// 4-bit instance sharing the same stimulus for counter saturation.
module tb_trigger_out_shaper;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_out_en;
  logic [31:0] reg_out_delay;
  logic [31:0] reg_out_width;
  logic [31:0] reg_out_holdoff;
  logic        reg_cnt_clr;
  logic        trigger_in;
  logic        trig_out;
  logic        busy;
  logic [31:0] accept_cnt;
  logic [31:0] drop_cnt;
  logic        trig_out_s;
  logic        busy_s;
  logic [3:0]  accept_cnt_s;
  logic [3:0]  drop_cnt_s;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  trigger_out_shaper #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .reg_out_en(reg_out_en),
    .reg_out_delay(reg_out_delay), .reg_out_width(reg_out_width),
    .reg_out_holdoff(reg_out_holdoff), .reg_cnt_clr(reg_cnt_clr),
    .trigger_in(trigger_in), .trig_out(trig_out), .busy(busy),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  trigger_out_shaper #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .reg_out_en(reg_out_en),
    .reg_out_delay(reg_out_delay[3:0]), .reg_out_width(reg_out_width[3:0]),
    .reg_out_holdoff(reg_out_holdoff[3:0]), .reg_cnt_clr(reg_cnt_clr),
    .trigger_in(trigger_in), .trig_out(trig_out_s), .busy(busy_s),
    .accept_cnt(accept_cnt_s), .drop_cnt(drop_cnt_s)
  );

  // Expected {trig_out, busy} after edge N+k for an edge accepted at N+s.
  function automatic logic [1:0] win(int s, int d, int w, int h, int k);
    int wp = (w == 0) ? 1 : w;
    int r  = k - s;
    logic t = (r >= 1 + d) && (r <= d + wp);
    logic b = (r >= 1) && (r <= d + wp + h);
    return {t, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    reg_cnt_clr = 1'b1;
    step();
    reg_cnt_clr = 1'b0;
  endtask

  task automatic set_dwh(int d, int w, int h);
    reg_out_delay   = d;
    reg_out_width   = w;
    reg_out_holdoff = h;
  endtask

  task automatic test_reset();
    rst = 1'b0; reg_out_en = 1'b1; reg_cnt_clr = 1'b0; trigger_in = 1'b0;
    set_dwh(0, 0, 0);
    #2;
    vectors++;
    if ({trig_out, busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_outputs got %b exp 00", {trig_out, busy});
    end
    vectors++;
    if (accept_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
      miscompares++; $display("FAIL reset_counters got %0d/%0d exp 0/0", accept_cnt, drop_cnt);
    end
    step(); step();
    rst = 1'b1;
    step(); step();
  endtask

  task automatic test_basic();
    logic [1:0] e;
    set_dwh(3, 5, 2); clear_counters();
    for (int k = 0; k < 14; k++) begin
      trigger_in = (k == 0);
      sb.push_back(win(0, 3, 5, 2, k));
      step();
      e = sb.pop_front();
      vectors++;
      if ({trig_out, busy} !== e) begin
        miscompares++; $display("FAIL basic k=%0d trig/busy got %b exp %b", k, {trig_out, busy}, e);
      end
    end
    trigger_in = 1'b0;
    vectors++;
    if (accept_cnt !== 32'd1 || drop_cnt !== 32'd0) begin
      miscompares++; $display("FAIL basic_counts got %0d/%0d exp 1/0", accept_cnt, drop_cnt);
    end
  endtask

  task automatic test_zero();
    logic [1:0] e;
    set_dwh(0, 0, 0); clear_counters();
    for (int k = 0; k < 7; k++) begin
      trigger_in = (k == 0) || (k == 3);
      sb.push_back(win(0, 0, 0, 0, k) | win(3, 0, 0, 0, k));
      step();
      e = sb.pop_front();
      vectors++;
      if ({trig_out, busy} !== e) begin
        miscompares++; $display("FAIL zero k=%0d trig/busy got %b exp %b", k, {trig_out, busy}, e);
      end
    end
    trigger_in = 1'b0;
    vectors++;
    if (accept_cnt !== 32'd2 || drop_cnt !== 32'd0) begin
      miscompares++; $display("FAIL zero_counts got %0d/%0d exp 2/0", accept_cnt, drop_cnt);
    end
  endtask

  task automatic test_retrigger();
    logic [1:0] e;
    set_dwh(3, 5, 2); clear_counters();
    // rises at 0, 4 and 11 (the last sits on the drop boundary)
    for (int k = 0; k < 16; k++) begin
      trigger_in = (k == 0) || (k == 4) || (k == 11);
      sb.push_back(win(0, 3, 5, 2, k));
      step();
      e = sb.pop_front();
      vectors++;
      if ({trig_out, busy} !== e) begin
        miscompares++; $display("FAIL retrig_a k=%0d trig/busy got %b exp %b", k, {trig_out, busy}, e);
      end
      if (k == 5) begin
        vectors++;
        if (drop_cnt !== 32'd1) begin
          miscompares++; $display("FAIL retrig_first_drop got %0d exp 1", drop_cnt);
        end
      end
    end
    vectors++;
    if (accept_cnt !== 32'd1 || drop_cnt !== 32'd2) begin
      miscompares++; $display("FAIL retrig_a_counts got %0d/%0d exp 1/2", accept_cnt, drop_cnt);
    end
    // rises at 0 and 12: the first edge past the window is accepted
    for (int k = 0; k < 28; k++) begin
      trigger_in = (k == 0) || (k == 12);
      sb.push_back(win(0, 3, 5, 2, k) | win(12, 3, 5, 2, k));
      step();
      e = sb.pop_front();
      vectors++;
      if ({trig_out, busy} !== e) begin
        miscompares++; $display("FAIL retrig_b k=%0d trig/busy got %b exp %b", k, {trig_out, busy}, e);
      end
    end
    trigger_in = 1'b0;
    vectors++;
    if (accept_cnt !== 32'd3 || drop_cnt !== 32'd2) begin
      miscompares++; $display("FAIL retrig_b_counts got %0d/%0d exp 3/2", accept_cnt, drop_cnt);
    end
  endtask

  task automatic test_level_hold();
    logic [1:0] e;
    set_dwh(0, 4, 0); clear_counters();
    for (int k = 0; k < 104; k++) begin
      trigger_in = (k < 100);
      if (k == 2) reg_out_width = 50;
      sb.push_back(win(0, 0, 4, 0, k));
      step();
      e = sb.pop_front();
      vectors++;
      if ({trig_out, busy} !== e) begin
        miscompares++; $display("FAIL level k=%0d trig/busy got %b exp %b", k, {trig_out, busy}, e);
      end
    end
    trigger_in = 1'b0;
    vectors++;
    if (accept_cnt !== 32'd1 || drop_cnt !== 32'd0) begin
      miscompares++; $display("FAIL level_counts got %0d/%0d exp 1/0", accept_cnt, drop_cnt);
    end
  endtask

  task automatic test_disable();
    logic [1:0] e;
    set_dwh(1, 5, 2); clear_counters();
    for (int k = 0; k < 8; k++) begin
      trigger_in = (k == 0);
      if (k == 3) reg_out_en = 1'b0;
      sb.push_back((k < 3) ? win(0, 1, 5, 2, k) : 2'b00);
      step();
      e = sb.pop_front();
      vectors++;
      if ({trig_out, busy} !== e) begin
        miscompares++; $display("FAIL disable k=%0d trig/busy got %b exp %b", k, {trig_out, busy}, e);
      end
    end
    trigger_in = 1'b0;
    vectors++;
    if (accept_cnt !== 32'd1 || drop_cnt !== 32'd0) begin
      miscompares++; $display("FAIL disable_counts got %0d/%0d exp 1/0", accept_cnt, drop_cnt);
    end
    reg_out_en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    set_dwh(1, 5, 2); clear_counters();
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    step(); step();
    vectors++;
    if ({trig_out, busy} !== 2'b11 || accept_cnt !== 32'd1) begin
      miscompares++; $display("FAIL rstmid_pre got %b cnt %0d exp 11 cnt 1", {trig_out, busy}, accept_cnt);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({trig_out, busy} !== 2'b00 || accept_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_async got %b cnt %0d/%0d exp 00 cnt 0/0", {trig_out, busy}, accept_cnt, drop_cnt);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    set_dwh(0, 0, 0);
    rst = 1'b0; step(); rst = 1'b1; step();
    for (int r = 0; r < 20; r++) begin
      trigger_in = 1'b1;
      step();
      trigger_in = 1'b0;
      step(); step(); step();
    end
    vectors++;
    if (accept_cnt_s !== 4'd15) begin
      miscompares++; $display("FAIL sat_accept4 got %0d exp 15", accept_cnt_s);
    end
    vectors++;
    if (accept_cnt !== 32'd20) begin
      miscompares++; $display("FAIL sat_accept32 got %0d exp 20", accept_cnt);
    end
    // clear held across the sampling edge and the increment edge of a rise
    trigger_in  = 1'b1;
    reg_cnt_clr = 1'b1;
    step();
    trigger_in = 1'b0;
    step();
    reg_cnt_clr = 1'b0;
    step(); step();
    vectors++;
    if (accept_cnt_s !== 4'd0 || accept_cnt !== 32'd0) begin
      miscompares++; $display("FAIL clr_priority got %0d/%0d exp 0/0", accept_cnt_s, accept_cnt);
    end
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    step(); step();
    vectors++;
    if (accept_cnt_s !== 4'd1 || accept_cnt !== 32'd1) begin
      miscompares++; $display("FAIL clr_resume got %0d/%0d exp 1/1", accept_cnt_s, accept_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_retrigger();
    test_level_hold();
    test_disable();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
